// File: rtl/inst_fetch.sv
// inst_fetch: turns current_pc into single-outstanding imem reads and queues {pc, instruction}
// pairs toward decode. Define IFETCH_BYPASS_EN for a same-cycle rvalid-to-decode path.
module inst_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] current_pc,
  output logic        pc_advance,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_empty;
  logic          w_resp;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_enter_req;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A response that lands in the same cycle as a redirect is simply discarded, so
  // WAIT only parks in DROP when the response is still to come.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!redirect && (r_count < DEPTH_C)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt)      w_state_nxt = redirect ? S_DROP : S_WAIT;
        else if (redirect) w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (imem_rvalid)   w_state_nxt = S_IDLE;
        else if (redirect) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid)   w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (r_state == S_REQ);
    pc_advance  = (r_state == S_REQ) && imem_gnt && !redirect;
    w_resp      = (r_state == S_WAIT) && imem_rvalid && !redirect;
    w_enter_req = (r_state == S_IDLE) && (w_state_nxt == S_REQ);
  end

  assign imem_addr = r_addr;

  // r_req_pc doubles as the response tag: only one request can be in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_addr   <= '0;
      r_req_pc <= '0;
    end else if (w_enter_req) begin
      r_addr   <= {current_pc[31:2], 2'b00};
      r_req_pc <= current_pc;
    end
  end

  assign w_empty = (r_count == '0);

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_empty && w_resp;
`else
  assign w_bypass = 1'b0;
`endif

  assign inst_valid = !w_empty || w_bypass;
  assign inst_out   = w_bypass ? imem_rdata : r_fifo_inst[r_rptr];
  assign inst_pc    = w_bypass ? r_req_pc   : r_fifo_pc[r_rptr];
  assign w_pop      = !w_empty && inst_ready && !redirect;
  assign w_push     = w_resp && !(w_bypass && inst_ready);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_inst[r_wptr] <= imem_rdata;
      r_fifo_pc[r_wptr]   <= r_req_pc;
    end
  end

  // Slots are reserved before the request goes out, so a push never finds the FIFO full.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; the hand-driven imem and decode sides
// follow the scenarios one cycle at a time.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] current_pc;
  logic        pc_advance;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.DEPTH(2)) dut (
    .clk(clk), .clr_n(clr_n), .current_pc(current_pc), .pc_advance(pc_advance),
    .redirect(redirect), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] pc);
    clr_n = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; current_pc = pc;
    step(); step();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(32'h0040_0000);
    step(); #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %0b want 1", imem_req); end
    clr_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL rst_pc_advance got %0b want 0", pc_advance); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %0b want 0", inst_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst got %h/%h want 0/0", inst_out, inst_pc); end
    step(); step(); #1;
    checks++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin errors++; $display("FAIL rst_hold got req=%0b adv=%0b want 0/0", imem_req, pc_advance); end
    // Stray response right after reset release must be ignored.
    clr_n = 1'b1; imem_gnt = 1'b0;
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_stray_rvalid got %0b want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_restart_req got %0b want 1", imem_req); end
  endtask

  task automatic test_straight_line();
    apply_reset(32'h0040_0000);
    inst_ready = 1'b1;
    step();
    imem_gnt = 1'b1; #1;
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL sl_addr got %h want 00400000", imem_addr); end
    checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL sl_adv_gnt got %0b want 1", pc_advance); end
    step();
    imem_gnt = 1'b0; current_pc = 32'h0040_0004; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL sl_adv_once got %0b want 0", pc_advance); end
`ifndef IFETCH_BYPASS_EN
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sl_early_valid got %0b want 0", inst_valid); end
    step();
    imem_rvalid = 1'b0; #1;
`endif
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL sl_valid got %0b want 1", inst_valid); end
    checks++; if (inst_out !== 32'h2008_0005) begin errors++; $display("FAIL sl_inst got %h want 20080005", inst_out); end
    checks++; if (inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL sl_pc got %h want 00400000", inst_pc); end
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sl_consumed got %0b want 0", inst_valid); end
  endtask

  task automatic test_backpressure();
    int grants;
    grants = 0;
    apply_reset(32'h0040_0000);
    step();
    imem_gnt = 1'b1; #1;
    grants += int'(pc_advance);
    step();
    imem_gnt = 1'b0; current_pc = 32'h0040_0004; imem_rvalid = 1'b1; imem_rdata = 32'hA100_0001;
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_idle_req got %0b want 0", imem_req); end
    step();
    imem_gnt = 1'b1; #1;
    checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL bp_addr2 got %h want 00400004", imem_addr); end
    grants += int'(pc_advance);
    step();
    imem_gnt = 1'b0; current_pc = 32'h0040_0008; imem_rvalid = 1'b1; imem_rdata = 32'hA200_0002;
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (inst_out !== 32'hA100_0001 || inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL bp_head got %h/%h want a1000001/00400000", inst_out, inst_pc); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin errors++; $display("FAIL bp_full_req cycle %0d got %0b want 0", i, imem_req); end
      step(); #1;
    end
    checks++; if (grants !== 2) begin errors++; $display("FAIL bp_grants got %0d want 2", grants); end
    inst_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_at_pop got %0b want 0", imem_req); end
    step();
    inst_ready = 1'b0; #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== 32'hA200_0002 || inst_pc !== 32'h0040_0004) begin errors++; $display("FAIL bp_second got v=%0b %h/%h want 1 a2000002/00400004", inst_valid, inst_out, inst_pc); end
    step(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL bp_resume got req=%0b addr=%h want 1 00400008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    apply_reset(32'h0040_0008);
    inst_ready = 1'b1;
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect = 1'b1; current_pc = 32'h0040_0100; #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL rw_adv got %0b want 0", pc_advance); end
    step();
    redirect = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_drop got req=%0b v=%0b want 0/0", imem_req, inst_valid); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_bypass got %0b want 0", inst_valid); end
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_push got v=%0b out=%h want 0", inst_valid, inst_out); end
    step();
    imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL rw_new_addr got req=%0b addr=%h want 1 00400100", imem_req, imem_addr); end
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; #1;
`ifndef IFETCH_BYPASS_EN
    step();
    imem_rvalid = 1'b0; #1;
`endif
    checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h1111_2222 || inst_pc !== 32'h0040_0100) begin errors++; $display("FAIL rw_new_inst got v=%0b %h/%h want 1 11112222/00400100", inst_valid, inst_out, inst_pc); end
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_stalled_grant();
    apply_reset(32'h0040_0013);
    inst_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0010 || pc_advance !== 1'b0) begin errors++; $display("FAIL sg_stall cycle %0d got req=%0b addr=%h adv=%0b want 1 00400010 0", i, imem_req, imem_addr, pc_advance); end
      step();
    end
    imem_gnt = 1'b1; #1;
    checks++; if (pc_advance !== 1'b1 || imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL sg_gnt got adv=%0b addr=%h want 1 00400010", pc_advance, imem_addr); end
    step();
    imem_gnt = 1'b0; current_pc = 32'h0040_0014; imem_rvalid = 1'b1; imem_rdata = 32'h3333_4444; #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL sg_adv_after got %0b want 0", pc_advance); end
`ifndef IFETCH_BYPASS_EN
    step();
    imem_rvalid = 1'b0; #1;
`endif
    checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h3333_4444 || inst_pc !== 32'h0040_0013) begin errors++; $display("FAIL sg_inst got v=%0b %h/%h want 1 33334444/00400013", inst_valid, inst_out, inst_pc); end
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_redirect_gnt_pop();
    apply_reset(32'h0040_0020);
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; current_pc = 32'h0040_0024; imem_rvalid = 1'b1; imem_rdata = 32'h5555_6666;
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h5555_6666) begin errors++; $display("FAIL rg_entry got v=%0b %h want 1 55556666", inst_valid, inst_out); end
    step();
    imem_gnt = 1'b1; redirect = 1'b1; inst_ready = 1'b1; current_pc = 32'h0040_0200; #1;
    checks++; if (imem_req !== 1'b1 || pc_advance !== 1'b0) begin errors++; $display("FAIL rg_adv got req=%0b adv=%0b want 1 0", imem_req, pc_advance); end
    step();
    imem_gnt = 1'b0; redirect = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rg_flush got v=%0b req=%0b want 0/0", inst_valid, imem_req); end
    step(); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rg_drop_hold got %0b want 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_8888; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rg_drop_bypass got %0b want 0", inst_valid); end
    step();
    imem_rvalid = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rg_discard got v=%0b req=%0b want 0/0", inst_valid, imem_req); end
    step(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL rg_resume got req=%0b addr=%h want 1 00400200", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect_wait();
    test_stalled_grant();
    test_redirect_gnt_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
